// File: rtl/multicycle_controller_if.sv
// Memory port handshake between the multi-cycle control FSM and the shared
// instruction/data memory. master = controller, slave = memory.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS core: one state per cycle, drives all
// datapath selects/enables, memory handshake via mem (master), counts retires.
module multicycle_controller (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 opcode,
  input  logic [5:0]                 funct,
  input  logic                       zero,
  multicycle_controller_if.master    mem,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic [1:0]                 pc_src,
  output logic                       alu_src_a,
  output logic [1:0]                 alu_src_b,
  output logic [2:0]                 alu_controller,
  output logic                       reg_we,
  output logic                       reg_write_addr,
  output logic                       reg_write_data,
  output logic                       retire,
  output logic                       illegal,
  output logic [31:0]                instret
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_ALU_WB,
    S_BRANCH,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_JUMP,
    S_JR
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  state_t state_n;

  // lw/sw and beq/bne flavour captured in DECODE so later
  // states do not depend on the opcode bus.
  logic is_sw_q;
  logic is_bne_q;

  logic op_rtype;
  logic op_mem;
  logic op_br;
  logic op_addi;
  logic op_j;
  logic fn_jr;
  logic fn_alu;
  logic [2:0] alu_fn;

  logic req;
  logic wr;
  logic adr;
  logic irw;
  logic pcw;
  logic we;
  logic ret;
  logic ill;

  assign op_rtype = (opcode == 6'b000000);
  assign op_mem   = (opcode == 6'b100011) ||
                    (opcode == 6'b101011);
  assign op_br    = (opcode == 6'b000100) ||
                    (opcode == 6'b000101);
  assign op_addi  = (opcode == 6'b001000);
  assign op_j     = (opcode == 6'b000010);
  assign fn_jr    = (funct == 6'b001000);
  assign fn_alu   = (funct == 6'b100000) ||
                    (funct == 6'b100010) ||
                    (funct == 6'b100100) ||
                    (funct == 6'b100101) ||
                    (funct == 6'b101010);

  always_comb begin
    unique case (funct)
      6'b100010: alu_fn = ALU_SUB;
      6'b100100: alu_fn = ALU_AND;
      6'b100101: alu_fn = ALU_OR;
      6'b101010: alu_fn = ALU_SLT;
      default:   alu_fn = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      is_sw_q  <= 1'b0;
      is_bne_q <= 1'b0;
      instret  <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        is_sw_q  <= opcode[3];
        is_bne_q <= opcode[0];
      end
      if (retire)
        instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_n        = state;
    req            = 1'b0;
    wr             = 1'b0;
    adr            = 1'b0;
    irw            = 1'b0;
    pcw            = 1'b0;
    we             = 1'b0;
    ret            = 1'b0;
    ill            = 1'b0;
    pc_src         = 2'b00;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    alu_controller = 3'b000;
    reg_write_addr = 1'b0;
    reg_write_data = 1'b0;
    unique case (state)
      S_FETCH: begin
        req            = 1'b1;
        alu_src_b      = 2'b01;
        alu_controller = ALU_ADD;
        irw            = mem.mem_ready;
        pcw            = mem.mem_ready;
        if (mem.mem_ready)
          state_n = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b      = 2'b11;
        alu_controller = ALU_ADD;
        unique case (1'b1)
          op_mem:            state_n = S_MEM_ADDR;
          op_rtype && fn_jr: state_n = S_JR;
          op_rtype && fn_alu: state_n = S_EXECUTE;
          op_br:             state_n = S_BRANCH;
          op_addi:           state_n = S_ADDI_EXEC;
          op_j:              state_n = S_JUMP;
          default: begin
            ill     = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a      = 1'b1;
        alu_src_b      = 2'b10;
        alu_controller = ALU_ADD;
        state_n        = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        req = 1'b1;
        adr = 1'b1;
        if (mem.mem_ready)
          state_n = S_MEM_WB;
      end
      S_MEM_WB: begin
        we             = 1'b1;
        reg_write_data = 1'b1;
        ret            = 1'b1;
        state_n        = S_FETCH;
      end
      S_MEM_WRITE: begin
        req = 1'b1;
        wr  = 1'b1;
        adr = 1'b1;
        ret = mem.mem_ready;
        if (mem.mem_ready)
          state_n = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a      = 1'b1;
        alu_controller = alu_fn;
        state_n        = S_ALU_WB;
      end
      S_ALU_WB: begin
        we             = 1'b1;
        reg_write_addr = 1'b1;
        ret            = 1'b1;
        state_n        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a      = 1'b1;
        alu_controller = ALU_SUB;
        pc_src         = 2'b01;
        pcw            = is_bne_q ? ~zero : zero;
        ret            = 1'b1;
        state_n        = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a      = 1'b1;
        alu_src_b      = 2'b10;
        alu_controller = ALU_ADD;
        state_n        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        we      = 1'b1;
        ret     = 1'b1;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pcw     = 1'b1;
        ret     = 1'b1;
        state_n = S_FETCH;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pcw     = 1'b1;
        ret     = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Reset kills every enable and any in-flight request immediately.
  assign mem.mem_req   = req & ~rst;
  assign mem.mem_write = wr & ~rst;
  assign mem.iord      = adr;
  assign ir_write      = irw & ~rst;
  assign pc_write      = pcw & ~rst;
  assign reg_we        = we & ~rst;
  assign retire        = ret & ~rst;
  assign illegal       = ill & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: a per-instruction model of the
// spec's state walk predicts every cycle's outputs, latency and instret.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_controller;
  logic        reg_we;
  logic        reg_write_addr;
  logic        reg_write_data;
  logic        retire;
  logic        illegal;
  logic [31:0] instret;

  multicycle_controller_if mif();

  multicycle_controller dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .funct          (funct),
    .zero           (zero),
    .mem            (mif),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .alu_controller (alu_controller),
    .reg_we         (reg_we),
    .reg_write_addr (reg_write_addr),
    .reg_write_data (reg_write_data),
    .retire         (retire),
    .illegal        (illegal),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  wire [17:0] obs_vec = {mif.mem_req, mif.mem_write, mif.iord,
                         ir_write, pc_write, pc_src, alu_src_a,
                         alu_src_b, alu_controller, reg_we,
                         reg_write_addr, reg_write_data,
                         retire, illegal};
  wire [6:0] gated = {mif.mem_req, mif.mem_write, ir_write,
                      pc_write, reg_we, retire, illegal};

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum {K_LW, K_SW, K_ALU, K_ADDI, K_BEQ,
                K_BNE, K_J, K_JR, K_ILL} kind_t;
  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX,
                P_AWB, P_AE, P_IWB, P_BR, P_JP, P_JRS} step_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op,
                                     input logic [5:0] fn);
    kind_t k;
    k = K_ILL;
    case (op)
      OP_LW:   k = K_LW;
      OP_SW:   k = K_SW;
      OP_BEQ:  k = K_BEQ;
      OP_BNE:  k = K_BNE;
      OP_ADDI: k = K_ADDI;
      OP_J:    k = K_J;
      OP_R: begin
        if (fn == FN_JR) k = K_JR;
        else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
          k = K_ALU;
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic int base_latency(input kind_t k);
    case (k)
      K_LW:                 return 5;
      K_SW, K_ALU, K_ADDI:  return 4;
      K_ILL:                return 2;
      default:              return 3;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return 3'b110;
      FN_AND:  return 3'b000;
      FN_OR:   return 3'b001;
      FN_SLT:  return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [17:0] vec(input step_t s, input logic rdy,
                                      input logic z, input kind_t k,
                                      input logic [5:0] fn);
    logic req, wr, ia, irw, pcw, asa, we, wa, wd, ret, ill;
    logic [1:0] ps, asb;
    logic [2:0] alu;
    {req, wr, ia, irw, pcw, asa, we, wa, wd, ret, ill} = '0;
    ps = '0;
    asb = '0;
    alu = '0;
    case (s)
      P_F: begin
        req = 1; asb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy;
      end
      P_D:   begin asb = 2'b11; alu = 3'b010; ill = (k == K_ILL); end
      P_MA:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      P_MR:  begin req = 1; ia = 1; end
      P_MWB: begin we = 1; wd = 1; ret = 1; end
      P_MW:  begin req = 1; wr = 1; ia = 1; ret = rdy; end
      P_EX:  begin asa = 1; alu = alu_code(fn); end
      P_AWB: begin we = 1; wa = 1; ret = 1; end
      P_AE:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      P_IWB: begin we = 1; ret = 1; end
      P_BR: begin
        asa = 1; alu = 3'b110; ps = 2'b01; ret = 1;
        pcw = (k == K_BNE) ? ~z : z;
      end
      P_JP:  begin ps = 2'b10; pcw = 1; ret = 1; end
      P_JRS: begin ps = 2'b11; pcw = 1; ret = 1; end
      default: ;
    endcase
    return {req, wr, ia, irw, pcw, ps, asa, asb, alu,
            we, wa, wd, ret, ill};
  endfunction

  // One instruction: fw fetch waits, mw memory waits (lw/sw only),
  // zsel < 0 randomises zero every cycle, else holds zsel[0].
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zsel);
    kind_t k;
    step_t steps[$];
    int    cyc, done_at, stalls, waits;
    logic  rdy, z, memstep;
    k = classify(op, fn);
    steps = '{P_F, P_D};
    case (k)
      K_LW:   begin steps.push_back(P_MA); steps.push_back(P_MR);
                    steps.push_back(P_MWB); end
      K_SW:   begin steps.push_back(P_MA); steps.push_back(P_MW); end
      K_ALU:  begin steps.push_back(P_EX); steps.push_back(P_AWB); end
      K_ADDI: begin steps.push_back(P_AE); steps.push_back(P_IWB); end
      K_BEQ, K_BNE: steps.push_back(P_BR);
      K_J:    steps.push_back(P_JP);
      K_JR:   steps.push_back(P_JRS);
      default: ;
    endcase
    cyc = 0;
    done_at = -1;
    stalls = 0;
    opcode = op;
    funct = fn;
    foreach (steps[i]) begin
      memstep = steps[i] inside {P_F, P_MR, P_MW};
      waits = (steps[i] == P_F) ? fw :
              (steps[i] == P_MR || steps[i] == P_MW) ? mw : 0;
      stalls += waits;
      for (int w = 0; w <= waits; w++) begin
        rdy = (w == waits);
        z = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
        zero = z;
        mif.mem_ready = memstep ? rdy : 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("%s.%s", k.name(), steps[i].name()),
              32'(obs_vec), 32'(vec(steps[i], rdy, z, k, fn)));
        if ((retire || illegal) && done_at < 0) done_at = cyc;
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    if (k != K_ILL) exp_instret++;
    check($sformatf("%s.latency", k.name()), 32'(done_at + 1),
          32'(base_latency(k) + stalls));
    check($sformatf("%s.instret", k.name()), instret, exp_instret);
  endtask

  logic [5:0] alu_fns [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

  task automatic run_random();
    logic [5:0] op, fn;
    int r, fw, mw;
    r = $urandom_range(0, 9);
    fn = 6'($urandom);
    fw = $urandom_range(0, 2);
    mw = 0;
    case (r)
      0: begin op = OP_LW; mw = $urandom_range(0, 2); end
      1: begin op = OP_SW; mw = $urandom_range(0, 2); end
      2: begin op = OP_R; fn = alu_fns[$urandom_range(0, 4)]; end
      3: op = OP_ADDI;
      4: op = OP_BEQ;
      5: op = OP_BNE;
      6: op = OP_J;
      7: begin op = OP_R; fn = FN_JR; end
      8: begin
        op = 6'($urandom);
        while (classify(op, FN_ADD) != K_ILL) op = 6'($urandom);
      end
      default: begin
        op = OP_R;
        while (classify(op, fn) != K_ILL) fn = 6'($urandom);
      end
    endcase
    run_instr(op, fn, fw, mw, -1);
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_gate", 32'(gated), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_instret", instret, 32'd0);

    run_instr(OP_LW, 6'd0, 0, 0, -1);
    run_instr(OP_SW, 6'd0, 0, 0, -1);
    run_instr(OP_R, FN_ADD, 0, 0, -1);
    run_instr(OP_ADDI, 6'd0, 0, 0, -1);
    run_instr(OP_BEQ, 6'd0, 0, 0, -1);
    run_instr(OP_J, 6'd0, 0, 0, -1);
    check("stream_instret", instret, 32'd6);

    run_instr(OP_J, 6'd0, 3, 0, -1);

    run_instr(OP_BEQ, 6'd0, 0, 0, 1);
    run_instr(OP_BEQ, 6'd0, 0, 0, 0);
    run_instr(OP_BNE, 6'd0, 0, 0, 1);
    run_instr(OP_BNE, 6'd0, 0, 0, 0);

    run_instr(6'b111111, 6'd0, 0, 0, -1);
    run_instr(OP_R, 6'b000000, 0, 0, -1);

    run_instr(OP_R, FN_JR, 0, 0, -1);
    run_instr(OP_R, FN_SUB, 0, 0, -1);
    run_instr(OP_R, FN_AND, 1, 0, -1);
    run_instr(OP_R, FN_OR, 0, 0, -1);
    run_instr(OP_R, FN_SLT, 0, 0, -1);
    run_instr(OP_LW, 6'd0, 1, 3, -1);
    run_instr(OP_SW, 6'd0, 0, 2, -1);

    // Reset while a lw is waiting in its data read
    opcode = OP_LW;
    funct = 6'd0;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    check("rmr.F", 32'(obs_vec), 32'(vec(P_F, 1'b1, zero, K_LW, 6'd0)));
    @(posedge clk); #1;
    @(negedge clk);
    check("rmr.D", 32'(obs_vec), 32'(vec(P_D, 1'b1, zero, K_LW, 6'd0)));
    @(posedge clk); #1;
    @(negedge clk);
    check("rmr.MA", 32'(obs_vec), 32'(vec(P_MA, 1'b1, zero, K_LW, 6'd0)));
    @(posedge clk); #1;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    check("rmr.MR", 32'(obs_vec), 32'(vec(P_MR, 1'b0, zero, K_LW, 6'd0)));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rmr.req_in_rst", 32'(mif.mem_req), 32'd0);
    check("rmr.gate", 32'(gated), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    check("rmr.instret", instret, 32'd0);
    @(negedge clk);
    check("rmr.post_req", 32'(mif.mem_req), 32'd1);
    check("rmr.post_iord", 32'(mif.iord), 32'd0);
    @(posedge clk); #1;

    repeat (300) run_random();

    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    exp_instret = 32'hFFFF_FFFF;
    run_instr(OP_J, 6'd0, 0, 0, -1);
    check("wrap", instret, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle MIPS core. It sequences a shared-memory multi-cycle datapath through fetch, decode, execute, memory and writeback, one state per cycle. It drives every datapath select and write-enable, and handshakes with a single instruction/data memory port that may stall. It sits beside the datapath and receives the opcode, funct and ALU zero flag from the instruction register and ALU.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag (current cycle)
- mem_ready  input  1  memory completes the request this cycle
- mem_req  output  1  memory access request; held until mem_ready
- mem_write  output  1  request is a store
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  output  1  load instruction register
- pc_write  output  1  load PC
- pc_src  output  2  PC source: 00 ALU result, 01 ALUOut, 10 {pc[31:28],instr[25:0],00}, 11 register rs
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 register B, 01 constant 4, 10 sign_imm, 11 sign_imm<<2
- alu_controller  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_we  output  1  register file write enable
- reg_write_addr  output  1  0 = rt, 1 = rd
- reg_write_data  output  1  0 = ALUOut, 1 = memory data
- retire  output  1  one-cycle pulse in the final cycle of each legal instruction
- illegal  output  1  one-cycle pulse on an undecodable instruction
- instret  output  32  retired-instruction counter

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP, JR. The state is registered. All outputs are combinational from the state, plus mem_ready and zero where stated. Outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. ir_write and pc_write equal mem_ready. Stay while !mem_ready; otherwise go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target to ALUOut). Next state by opcode:
  - lw 100011 and sw 101011 → MEM_ADDR.
  - R-type 000000: funct 001000 → JR; add 100000, sub 100010, and 100100, or 100101, slt 101010 → EXECUTE.
  - beq 000100, bne 000101 → BRANCH.
  - addi 001000 → ADDI_EXEC.
  - j 000010 → JUMP.
  - Anything else: illegal=1 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Go to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_req=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_write_addr=0, reg_write_data=1, retire → FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, iord=1. On mem_ready: retire → FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_controller from funct → ALU_WB.
- ALU_WB: reg_we=1, reg_write_addr=1, reg_write_data=0, retire → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_write = zero for beq, !zero for bne. retire → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, add → ADDI_WB.
- ADDI_WB: reg_we=1, reg_write_addr=0, reg_write_data=0, retire → FETCH.
- JUMP: pc_src=10, pc_write=1, retire → FETCH.
- JR: pc_src=11, pc_write=1, retire → FETCH.
- Opcode and funct are sampled only in DECODE and EXECUTE. The instruction register holds them stable from DECODE through the final state.
- instret increments by 1 on each clock edge where retire=1. It wraps from 0xFFFFFFFF to 0. It does not increment on illegal.

## Timing
- Reset: when rst=1 at an edge, the state becomes FETCH and instret becomes 0. While rst=1, the following are forced to 0 combinationally: mem_req, mem_write, ir_write, pc_write, reg_we, retire, illegal. This applies mid-instruction too. No partial writes complete, and an outstanding memory request is dropped.
- With zero-wait memory (mem_ready=1 on the request cycle), latencies are:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, bne, j, jr: 3 cycles.
  - illegal: 2 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. During a stall, all outputs hold their values and no enable is asserted.
- Once mem_req rises, mem_req, iord and mem_write stay constant until the cycle where mem_ready=1. Only reset aborts a request.
- mem_ready is ignored in states other than FETCH, MEM_READ and MEM_WRITE.
- retire and illegal are never asserted in the same cycle, and neither lasts longer than 1 cycle.

## Test plan
- Reset: assert rst mid-MEM_READ, then release. Required: mem_req=0 during reset, instret=0, FETCH is the first state after release, and mem_req=1 with iord=0 on the first post-reset cycle.
- Zero-wait stream of lw, sw, add, addi, beq, j. Required: cycle counts 5/4/4/4/3/3, instret=6, and the per-state output vector matches Operation at every cycle.
- Fetch stall: hold mem_ready=0 for 3 cycles in FETCH. Required: FETCH is held 4 cycles, mem_req stays high, and ir_write/pc_write pulse only on the ready cycle.
- Branch: beq with zero=1 gives pc_write=1, pc_src=01. beq with zero=0 gives pc_write=0. bne gives the inverse. retire is asserted in all cases.
- Illegal: opcode 111111, and separately R-type funct 000000. Required: illegal pulses in DECODE, the next state is FETCH, no reg_we or mem_write, and instret is unchanged.
- Wrap: preload instret to 0xFFFFFFFF via force, then retire j. Required: instret=0x00000000.
